// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit path among N_REQ requesters.
// A granted word is latched, handed to the UART once it is ready, then followed by a fixed gap.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int N_TX_BYTES = 2,
  parameter int GAP_CYCLES = 20000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ*N_TX_BYTES*8-1:0] i_req_data,
  input  logic                          i_tx_ready,
  output logic [N_REQ-1:0]              o_ack,
  output logic                          o_send_data,
  output logic [N_TX_BYTES*8-1:0]       o_tx_bits,
  output logic [$clog2(N_REQ)-1:0]      o_grant_id,
  output logic                          o_busy
);

  localparam int W   = N_TX_BYTES * 8;
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(GAP_CYCLES + 1);

  // state | meaning
  // IDLE  | waiting for any request
  // ARM   | word latched, waiting for the UART to be ready
  // SEND  | send_data pulse
  // GAP   | hold-off while the serializer drains the word
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_ack;
  logic             r_send_data;
  logic             r_busy;
  logic [W-1:0]     r_tx_bits;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_last;
  logic [CW-1:0]    r_cnt;

  logic             w_found;
  logic [IDW-1:0]   w_win;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    logic [IDW:0]   v_sum;
    logic [IDW-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_sum   = '0;
    v_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      v_sum = {1'b0, r_last} + (IDW+1)'(k);
      if (v_sum >= (IDW+1)'(N_REQ)) begin
        v_sum = v_sum - (IDW+1)'(N_REQ);
      end
      v_idx = v_sum[IDW-1:0];
      if (!w_found && i_req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ack       <= '0;
      r_send_data <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_bits   <= '0;
      r_grant_id  <= '0;
      r_last      <= IDW'(N_REQ - 1);
      r_cnt       <= '0;
    end else begin
      r_ack       <= '0;
      r_send_data <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= ARM;
            r_busy     <= 1'b1;
            r_tx_bits  <= i_req_data[w_win*W +: W];
            r_grant_id <= w_win;
            r_last     <= w_win;
            r_ack      <= N_REQ'(1) << w_win;
          end
        end
        ARM: begin
          if (i_tx_ready) begin
            r_state     <= SEND;
            r_send_data <= 1'b1;
          end
        end
        SEND: begin
          r_state <= GAP;
          r_cnt   <= CW'(GAP_CYCLES - 1);
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_send_data = r_send_data;
  assign o_busy      = r_busy;
  assign o_tx_bits   = r_tx_bits;
  assign o_grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants, a monitor
// checks every ack and send_data pulse against them.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int NB    = 2;
  localparam int GAP   = 8;
  localparam int W     = NB * 8;

  logic                 clk;
  logic                 rst;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   req_data;
  logic                 tx_ready;
  logic [N_REQ-1:0]     ack;
  logic                 send_data;
  logic [W-1:0]         tx_bits;
  logic [1:0]           grant_id;
  logic                 busy;

  uart_tx_arbiter #(.N_REQ(N_REQ), .N_TX_BYTES(NB), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .i_tx_ready(tx_ready), .o_ack(ack), .o_send_data(send_data),
    .o_tx_bits(tx_bits), .o_grant_id(grant_id), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t send_q[$];
  int   ack_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic expect_grant(input int id);
    exp_t e;
    e.id   = id;
    e.data = req_data[id*W +: W];
    ack_q.push_back(id);
    send_q.push_back(e);
  endtask

  task automatic wait_send(output int t);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (send_data) begin
        seen = 1'b1;
        break;
      end
    end
    chk("send_seen", 32'(seen), 32'd1);
    t = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // Monitor: every ack and send_data pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (ack != '0) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        int id;
        id = ack_q.pop_front();
        chk("ack_onehot", 32'(ack), 32'(1 << id));
        chk("ack_grant_id", 32'(grant_id), 32'(id));
      end
    end
    if (send_data) begin
      if (send_q.size() == 0) begin
        chk("unexpected_send", 32'(send_data), 32'd0);
      end else begin
        exp_t e;
        e = send_q.pop_front();
        chk("send_grant_id", 32'(grant_id), 32'(e.id));
        chk("send_tx_bits", 32'(tx_bits), 32'(e.data));
      end
    end
  end

  initial begin
    int t[5];
    int n;
    bit stall_ok;
    bit seen;
    logic [W-1:0] saved;

    rst      = 1'b1;
    req      = 4'b1111;
    tx_ready = 1'b1;
    req_data = '0;
    for (int i = 0; i < N_REQ; i++) set_slice(i, 16'hA000 + 16'(i));

    // Reset held two cycles with all requests pending.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_send", 32'(send_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_bits", 32'(tx_bits), 32'd0);
    end

    // Continuous requests: order 0,1,2,3,0 spaced GAP+3 cycles.
    expect_grant(0);
    expect_grant(1);
    expect_grant(2);
    expect_grant(3);
    expect_grant(0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) wait_send(t[i]);
    req = '0;
    for (int i = 1; i < 5; i++) chk("send_spacing", 32'(t[i] - t[i-1]), 32'(GAP + 3));
    wait_idle();

    // Single request to requester 2.
    set_slice(2, 16'hBEEF);
    req = 4'b0100;
    expect_grant(2);
    tick();
    chk("single_ack", 32'(ack), 32'b0100);
    chk("single_busy", 32'(busy), 32'd1);
    req = '0;
    tick();
    chk("single_send", 32'(send_data), 32'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n = i;
      if (!busy) break;
    end
    chk("single_busy_drop", 32'(n), 32'd9);

    // tx_ready stall for five cycles after ack.
    tx_ready = 1'b0;
    set_slice(0, 16'h1234);
    req = 4'b0001;
    expect_grant(0);
    tick();
    chk("stall_ack", 32'(ack), 32'b0001);
    saved = tx_bits;
    req = '0;
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (send_data) stall_ok = 1'b0;
    end
    chk("stall_no_send", 32'(stall_ok), 32'd1);
    tx_ready = 1'b1;
    tick();
    chk("stall_send", 32'(send_data), 32'd1);
    chk("stall_tx_bits", 32'(tx_bits), 32'(saved));
    chk("stall_tx_bits_val", 32'(tx_bits), 32'h1234);
    wait_idle();

    // Round-robin wrap: grant 1, then 1010 gives 3 then 1.
    set_slice(1, 16'h1111);
    req = 4'b0010;
    expect_grant(1);
    tick();
    chk("wrap_first_ack", 32'(ack), 32'b0010);
    req = '0;
    wait_idle();
    set_slice(3, 16'h3333);
    set_slice(1, 16'h1112);
    req = 4'b1010;
    expect_grant(3);
    expect_grant(1);
    tick();
    chk("wrap_ack3", 32'(ack), 32'b1000);
    req = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack != '0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wrap_ack1_seen", 32'(seen), 32'd1);
    chk("wrap_ack1", 32'(ack), 32'b0010);
    req = '0;
    wait_idle();

    // Reset in the middle of GAP.
    req = 4'b0100;
    expect_grant(2);
    tick();
    chk("midgap_ack", 32'(ack), 32'b0100);
    req = '0;
    wait_send(t[0]);
    tick();
    tick();
    tick();
    chk("midgap_in_gap", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midgap_busy", 32'(busy), 32'd0);
    chk("midgap_tx_bits", 32'(tx_bits), 32'd0);
    chk("midgap_grant_id", 32'(grant_id), 32'd0);
    req = 4'b1111;
    expect_grant(0);
    tick();
    chk("midgap_regrant", 32'(ack), 32'b0001);
    req = '0;
    wait_idle();

    tick();
    tick();
    chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
    chk("send_q_empty", 32'(send_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
